// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/ready port between the fetch stage (master) and
// instruction memory (slave). Address is held stable while imem_req is high.
interface instruction_fetch_if #(
  parameter int unsigned AW = 32
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rdy;
  logic [31:0]   imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdy,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdy,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches over a req/rdy port with variable latency,
// and presents the latched instruction to the control unit.
//
// state | meaning
// IDLE  | first cycle after reset release
// FETCH | request outstanding at pc_cur, waiting for imem_rdy
// VALID | instruction held for pc_cur, waiting for advance
// HALT  | misaligned next PC seen, stopped until reset
module instruction_fetch #(
  parameter int unsigned    AW        = 32,
  parameter logic [AW-1:0]  RESET_PC  = '0,
  parameter logic [31:0]    NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  instruction_fetch_if.master imem,
  input  logic                advance,
  input  logic                take_branch,
  input  logic [31:0]         branch_offset,
  output logic [31:0]         instr,
  output logic [6:0]          opcode,
  output logic                funct7_5,
  output logic                instr_valid,
  output logic [AW-1:0]       pc_cur,
  output logic                halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [31:0]   instr_q;
  logic          req_q;
  logic          valid_q;
  logic          halted_q;

  logic [AW-1:0] off_aw;
  logic [AW-1:0] pc_d;

  // Signed cast truncates or sign-extends the offset to the PC width.
  assign off_aw = AW'($signed(branch_offset));
  assign pc_d   = pc_q + (take_branch ? off_aw : AW'(4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_rdy) begin
            state_q <= VALID;
            instr_q <= imem.imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        VALID: begin
          if (advance) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            if (pc_d[1:0] != 2'b00) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= FETCH;
              pc_q    <= pc_d;
              req_q   <= 1'b1;
            end
          end
        end
        HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;

  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign funct7_5    = instr_q[30];
  assign instr_valid = valid_q;
  assign pc_cur      = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a 32-bit instance with a variable-wait
// memory model and an 8-bit instance for PC wrap and offset truncation.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit DUT
  logic        rst_n = 1'b0;
  logic        advance = 1'b0;
  logic        take_branch = 1'b0;
  logic [31:0] branch_offset = '0;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic        funct7_5;
  logic        instr_valid;
  logic [31:0] pc_cur;
  logic        halted;

  instruction_fetch_if #(.AW(32)) if1 ();

  instruction_fetch #(.AW(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (if1.master),
    .advance       (advance),
    .take_branch   (take_branch),
    .branch_offset (branch_offset),
    .instr         (instr),
    .opcode        (opcode),
    .funct7_5      (funct7_5),
    .instr_valid   (instr_valid),
    .pc_cur        (pc_cur),
    .halted        (halted)
  );

  // Memory model: rdy after mem_wait cycles of req; rdy_force injects a stray pulse.
  logic [31:0] mem [0:63];
  int          mem_wait = 0;
  int          wait_cnt = 0;
  logic        rdy_force = 1'b0;

  assign if1.imem_rdy   = (if1.imem_req && (wait_cnt == mem_wait)) || rdy_force;
  assign if1.imem_rdata = rdy_force ? 32'hDEAD_BEEF : mem[if1.imem_addr[7:2]];

  always @(posedge clk) begin
    if (!if1.imem_req || if1.imem_rdy) wait_cnt <= 0;
    else                               wait_cnt <= wait_cnt + 1;
  end

  // 8-bit DUT, RESET_PC near the top of the address space
  logic        rst2_n = 1'b0;
  logic        advance2 = 1'b0;
  logic        take_branch2 = 1'b0;
  logic [31:0] branch_offset2 = '0;
  logic [31:0] instr2;
  logic [6:0]  opcode2;
  logic        funct7_5_2;
  logic        instr_valid2;
  logic [7:0]  pc_cur2;
  logic        halted2;

  instruction_fetch_if #(.AW(8)) if2 ();

  assign if2.imem_rdy   = if2.imem_req;
  assign if2.imem_rdata = 32'h0000_0033;

  instruction_fetch #(.AW(8), .RESET_PC(8'hFC)) dut2 (
    .clk           (clk),
    .rst_n         (rst2_n),
    .imem          (if2.master),
    .advance       (advance2),
    .take_branch   (take_branch2),
    .branch_offset (branch_offset2),
    .instr         (instr2),
    .opcode        (opcode2),
    .funct7_5      (funct7_5_2),
    .instr_valid   (instr_valid2),
    .pc_cur        (pc_cur2),
    .halted        (halted2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic adv(input logic tb, input logic [31:0] off);
    advance       = 1'b1;
    take_branch   = tb;
    branch_offset = off;
    tick();
    advance       = 1'b0;
    take_branch   = 1'b0;
    branch_offset = '0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 32'h4000_0033 + (i << 12);
    mem[0] = 32'h0050_0093;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",    {31'b0, if1.imem_req}, 32'd0);
    chk("rst_pc",     pc_cur, 32'h0);
    chk("rst_instr",  instr, NOP);
    chk("rst_valid",  {31'b0, instr_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);

    // 1: zero-wait first fetch
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t1_req",   {31'b0, if1.imem_req}, 32'd1);
    chk("t1_addr",  if1.imem_addr, 32'h0);
    chk("t1_nop",   instr, NOP);
    chk("t1_val0",  {31'b0, instr_valid}, 32'd0);
    tick();
    chk("t1_valid",  {31'b0, instr_valid}, 32'd1);
    chk("t1_instr",  instr, 32'h0050_0093);
    chk("t1_opcode", {25'b0, opcode}, 32'h13);
    chk("t1_reqlo",  {31'b0, if1.imem_req}, 32'd0);

    // 2: three-wait fetch of pc 4
    mem_wait = 3;
    adv(1'b0, 32'h0);
    chk("t2_pc", pc_cur, 32'h4);
    n = 0;
    while (if1.imem_req && n < 20) begin
      chk("t2_addr", if1.imem_addr, 32'h4);
      chk("t2_nop",  instr, NOP);
      tick();
      n++;
    end
    chk("t2_req_cycles", n, 32'd4);
    chk("t2_valid",  {31'b0, instr_valid}, 32'd1);
    chk("t2_instr",  instr, 32'h4000_1033);
    chk("t2_f7_5",   {31'b0, funct7_5}, 32'd1);

    // 3: sequential and backward branch
    mem_wait = 0;
    repeat (3) begin
      adv(1'b0, 32'h0);
      wait_valid("t3_walk_valid");
    end
    chk("t3_pc10", pc_cur, 32'h10);
    adv(1'b0, 32'h0);
    chk("t3_seq", pc_cur, 32'h14);
    wait_valid("t3_seq_valid");
    adv(1'b1, 32'hFFFF_FFF8);
    chk("t3_br_back", pc_cur, 32'h0C);
    wait_valid("t3_br_valid");
    chk("t3_instr", instr, 32'h4000_3033);
    adv(1'b1, 32'h0);
    chk("t3_refetch_pc",  pc_cur, 32'h0C);
    chk("t3_refetch_req", {31'b0, if1.imem_req}, 32'd1);
    wait_valid("t3_refetch_valid");
    adv(1'b1, 32'h14);
    chk("t3_to20", pc_cur, 32'h20);
    wait_valid("t3_to20_valid");

    // 4: misaligned target halts
    adv(1'b1, 32'h6);
    chk("t4_halted", {31'b0, halted}, 32'd1);
    chk("t4_req",    {31'b0, if1.imem_req}, 32'd0);
    chk("t4_pc",     pc_cur, 32'h20);
    chk("t4_valid",  {31'b0, instr_valid}, 32'd0);
    chk("t4_instr",  instr, NOP);
    advance   = 1'b1;
    rdy_force = 1'b1;
    repeat (3) tick();
    advance   = 1'b0;
    rdy_force = 1'b0;
    chk("t4_stay_halted", {31'b0, halted}, 32'd1);
    chk("t4_stay_pc",     pc_cur, 32'h20);
    chk("t4_stay_instr",  instr, NOP);

    // 6: reset mid-wait, stray rdy in IDLE ignored
    mem_wait = 3;
    rst_n = 1'b0;
    tick();
    chk("t6_halt_clr", {31'b0, halted}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_fetch_req", {31'b0, if1.imem_req}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_req", {31'b0, if1.imem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_force = 1'b1;
    tick();
    rdy_force = 1'b0;
    chk("t6_idle_ignored", instr, NOP);
    chk("t6_idle_valid",   {31'b0, instr_valid}, 32'd0);
    chk("t6_refetch_req",  {31'b0, if1.imem_req}, 32'd1);
    chk("t6_refetch_addr", if1.imem_addr, 32'h0);
    wait_valid("t6_valid");
    chk("t6_instr", instr, 32'h0050_0093);
    chk("t6_pc",    pc_cur, 32'h0);

    // 5: 8-bit PC wrap and offset truncation
    @(negedge clk);
    rst2_n = 1'b1;
    tick();
    tick();
    chk("t5_valid", {31'b0, instr_valid2}, 32'd1);
    chk("t5_pc_fc", {24'b0, pc_cur2}, 32'hFC);
    advance2 = 1'b1;
    tick();
    advance2 = 1'b0;
    chk("t5_wrap",   {24'b0, pc_cur2}, 32'h00);
    chk("t5_halted", {31'b0, halted2}, 32'd0);
    tick();
    chk("t5_valid2", {31'b0, instr_valid2}, 32'd1);
    advance2 = 1'b1;
    take_branch2 = 1'b1;
    branch_offset2 = 32'hFFFF_FFFC;
    tick();
    advance2 = 1'b0;
    take_branch2 = 1'b0;
    chk("t5_trunc", {24'b0, pc_cur2}, 32'hFC);
    chk("t5_trunc_halt", {31'b0, halted2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
